// File: rtl/factorial_inverse_seq.sv
// factorial_inverse_seq: largest n <= NMAX with n! <= V, using a 4-cycle shift-add multiply per step
module factorial_inverse_seq #(
  parameter int VW   = 14,
  parameter int NW   = 3,
  parameter int NMAX = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] in_value,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] out_n,
  output logic          out_exact,
  output logic          out_err
);
  typedef enum logic [1:0] {IDLE, MUL, CMP, DONE} state_t;
  state_t state, state_n;
  logic [VW-1:0] v, acc;
  logic [VW+3:0] prod;
  logic [NW-1:0] n, n_inc;
  logic [3:0] m;
  logic [1:0] cnt;
  logic exact, accept, stop, hit;
  assign accept = in_valid & in_ready;
  assign m      = 4'(n) + 4'd1;
  assign n_inc  = n + NW'(1);
  assign stop   = prod > {4'b0, v};
  assign hit    = prod == {4'b0, v};
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (in_value == '0 ? DONE : MUL) : IDLE;
      MUL:  state_n = cnt == 2'd3 ? CMP : MUL;
      CMP:  state_n = (stop || n_inc == NW'(NMAX)) ? DONE : MUL;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_n     <= '0;
      out_exact <= 1'b0;
      out_err   <= 1'b0;
      v         <= '0;
      acc       <= '0;
      prod      <= '0;
      n         <= '0;
      cnt       <= '0;
      exact     <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= state_n == IDLE;
      out_valid <= state_n == DONE;
      cnt       <= state == MUL ? cnt + 2'd1 : 2'd0;
      case (state)
        IDLE: if (accept) begin
          v         <= in_value;
          acc       <= VW'(1);
          n         <= NW'(1);
          exact     <= in_value == VW'(1);
          prod      <= '0;
          out_err   <= in_value == '0;
          out_n     <= '0;
          out_exact <= 1'b0;
        end
        MUL: if (m[cnt]) prod <= prod + ({4'b0, acc} << cnt);
        CMP: if (stop) begin
          out_n     <= n;
          out_exact <= exact;
        end else begin
          acc       <= prod[VW-1:0];
          n         <= n_inc;
          exact     <= hit;
          prod      <= '0;
          out_n     <= n_inc;
          out_exact <= hit;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_factorial_inverse_seq.sv
// tb_factorial_inverse_seq: directed checks of results, latency, backpressure and reset abort
module tb_factorial_inverse_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [13:0] in_value = '0;
  logic in_ready, out_valid, out_exact, out_err;
  logic [2:0] out_n;
  int checks = 0, errors = 0;

  factorial_inverse_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n), .out_exact(out_exact),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model(input int val, output int en, output int ex, output int lat);
    int f = 1;
    en = 0;
    for (int i = 1; i <= 7; i++) begin
      f = f * i;
      if (f <= val) en = i;
    end
    f = 1;
    for (int i = 1; i <= en; i++) f = f * i;
    ex = (val != 0 && f == val) ? 1 : 0;
    lat = val == 0 ? 1 : 5 * (en < 7 ? en : 6) + 1;
  endfunction

  task automatic run(input logic [13:0] val, input int en, input int ex, input int er,
                     input int lat, input int hold);
    int l;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_value = val;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = 14'($urandom);
    l = 1;
    chk("in_ready_busy", in_ready, 0);
    while (!out_valid && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
    chk("latency", l, lat);
    chk("out_n", out_n, en);
    chk("out_exact", out_exact, ex);
    chk("out_err", out_err, er);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_n", out_n, en);
      chk("hold_exact", out_exact, ex);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int en, ex, lat;
    int vals[$];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_n", out_n, 0);
    chk("rst_out_exact", out_exact, 0);
    chk("rst_out_err", out_err, 0);
    @(negedge clk);
    rst = 1'b0;
    run(14'd120, 5, 1, 0, 26, 0);
    run(14'd719, 5, 0, 0, 26, 0);
    run(14'd720, 6, 1, 0, 31, 0);
    run(14'd1, 1, 1, 0, 6, 0);
    run(14'd0, 0, 0, 1, 1, 0);
    run(14'd2, 2, 1, 0, 11, 0);
    run(14'd5040, 7, 1, 0, 31, 0);
    run(14'd16383, 7, 0, 0, 31, 0);
    run(14'd24, 4, 1, 0, 21, 10);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 14'd5040;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    run(14'd6, 3, 1, 0, 16, 0);
    for (int f = 1, i = 1; i <= 7; i++) begin
      f = f * i;
      vals.push_back(f - 1);
      vals.push_back(f);
      vals.push_back(f + 1);
    end
    for (int i = 0; i < 12; i++) vals.push_back(int'($urandom_range(0, 16383)));
    vals.push_back(16383);
    vals.push_back(5039);
    foreach (vals[i]) begin
      model(vals[i], en, ex, lat);
      run(14'(vals[i]), en, ex, vals[i] == 0 ? 1 : 0, lat, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
